clock_ctrl: RTL
===============

// Module: clock_ctrl
// PURPOSE
//   Sequencer for the BCD time-of-day counters. Owns the 1 Hz prescaler and the seconds
//   counter, and issues one-cycle increment pulses to the external minute (up60) and hour
//   (up24) counters. Also runs the set-time FSM: mode button selects a field, inc button
//   steps it, and a held inc button auto-repeats.
// PARAMETERS
//   TICK_DIV      100_000_000  ck cycles per second tick (>=8, multiple of 4)
//   HOLD_CYCLES    50_000_000  continuous inc hold before auto-repeat starts
//   REPEAT_CYCLES  10_000_000  period between auto-repeat pulses
// PORTS
//   ck        in   1  clock, all state on posedge
//   rst_n     in   1  asynchronous reset, active-low
//   btn_mode  in   1  mode button level, already synchronised and debounced
//   btn_inc   in   1  increment button level, already synchronised and debounced
//   min_d1    in   4  minute tens digit (BCD) from minute counter
//   min_d0    in   4  minute units digit (BCD) from minute counter
//   up60      out  1  one-cycle minute increment pulse
//   up24      out  1  one-cycle hour increment pulse
//   sec_d1    out  4  seconds tens digit (BCD, 0-5)
//   sec_d0    out  4  seconds units digit (BCD, 0-9)
//   mode      out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN (3 unused, never driven)
//   blink     out  1  field-blink enable for display, 0 in RUN
// BEHAVIOUR
//   Reset: state RUN, prescaler 0, sec 00, up60=up24=0, blink=0, edge/hold timers 0.
//   All outputs registered.
//   Prescaler: counts 0..TICK_DIV-1 in RUN only; tick = (count==TICK_DIV-1).
//   RUN, on tick: seconds BCD +1; on 59->00, up60=1 for exactly the next cycle. up24=1
//     in that same cycle iff min_d1==5 && min_d0==9 sampled at the tick edge.
//   FSM on btn_mode rising edge: RUN->SET_HOUR->SET_MIN->RUN.
//     Entering SET_HOUR: sec forced to 00, prescaler cleared and frozen.
//     SET_MIN->RUN: prescaler restarts at 0; first tick TICK_DIV cycles later.
//   SET states: no tick-driven increments. btn_inc rising edge -> one pulse, latency 1
//     cycle: up24 in SET_HOUR, up60 in SET_MIN. No carry: up24 never pulses in SET_MIN.
//   Auto-repeat: inc held HOLD_CYCLES cycles after the edge -> pulse, then one pulse every
//     REPEAT_CYCLES while held. Release resets the timer. btn_inc ignored in RUN.
//   Simultaneous btn_mode and btn_inc edges: mode wins, inc pulse suppressed, timer reset.
//   Mode change while inc held: timer reset; no pulse until a new inc edge.
//   blink: in SET states toggles every TICK_DIV/4 cycles, starting at 1 on entry; 0 in RUN.
//   up60 and up24 never asserted for two consecutive cycles.
//   rst_n low mid-operation (incl. mid-pulse): all outputs return to reset values at once.
// STRUCTURE
//   Shared package clock_pkg: mode encodings (MODE_RUN/SET_HOUR/SET_MIN), BCD limits
//     (SEC_MAX=59, MIN_MAX_D1=5, MIN_MAX_D0=9).
//   Sub-module btn_repeat (params HOLD_CYCLES, REPEAT_CYCLES): edge detect + hold/repeat
//     timer, output a one-cycle step pulse; enabled only in SET states.
//   Top: prescaler, seconds BCD counter, mode FSM, blink divider, pulse output regs.
// TESTING  (TICK_DIV=8, HOLD_CYCLES=20, REPEAT_CYCLES=5)
//   Reset then 8*60 cycles RUN, min=12 -> sec 00..59..00, single up60 pulse, up24=0.
//   RUN, sec=59, min_d1=5, min_d0=9 at tick -> up60=up24=1 same cycle, one cycle wide.
//   Mode edge x1 at sec=37 -> mode=1, sec=00, prescaler frozen; inc edge -> up24 pulse 1 cycle later.
//   SET_MIN, inc held 36 cycles -> 1 edge pulse, then pulses at hold+20, +25, +30, +35 (5 total), up24=0.
//   Mode and inc edges in same cycle from SET_HOUR -> mode=2, no up24/up60 pulse.
//   rst_n low during SET_MIN with inc held -> mode=0, sec 00, pulses 0 immediately.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared encodings and BCD limits for the time-of-day sequencer.
package clock_pkg;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

    localparam int SEC_MAX = 59;
    localparam logic [3:0] SEC_MAX_D1 = 4'(SEC_MAX / 10);
    localparam logic [3:0] SEC_MAX_D0 = 4'(SEC_MAX % 10);
    localparam logic [3:0] MIN_MAX_D1 = 4'd5;
    localparam logic [3:0] MIN_MAX_D0 = 4'd9;

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        logic [1:0] n;
        n = MODE_RUN;
        unique case (m)
            MODE_RUN:      n = MODE_SET_HOUR;
            MODE_SET_HOUR: n = MODE_SET_MIN;
            default:       n = MODE_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/clock_ctrl_btn_repeat.sv
// Increment-button edge detector with hold-to-repeat timer.
module btn_repeat
    import clock_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic ck,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic btn,
    output logic step
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] FIRE   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - REPEAT_CYCLES + 1);

    logic          prev;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fire;

    // cnt==0 means disarmed: a held button only repeats after a fresh edge
    assign rise = btn & ~prev;
    assign fire = btn & prev & (cnt == FIRE);
    assign step = en & ~clr & (rise | fire);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= btn;
            if (!en || clr || !btn) begin
                cnt <= '0;
            end else if (rise) begin
                cnt <= CW'(1);
            end else if (fire) begin
                cnt <= RELOAD;
            end else if (cnt != '0) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day sequencer: 1 Hz prescaler, seconds counter, set-time FSM,
// and minute/hour increment pulses for the external counters.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV      = 100_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] min_d1,
    input  logic [3:0] min_d0,
    output logic       up60,
    output logic       up24,
    output logic [3:0] sec_d1,
    output logic [3:0] sec_d0,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(TICK_DIV / 4);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(TICK_DIV / 4 - 1);

    logic [PW-1:0] presc;
    logic [BW-1:0] bcnt;
    logic          mode_prev;
    logic          mode_edge;
    logic          in_set;
    logic          tick;
    logic          sec_wrap;
    logic          step;

    assign mode_edge = btn_mode & ~mode_prev;
    assign in_set    = (mode != MODE_RUN);
    assign tick      = !in_set && (presc == PRE_LAST);
    assign sec_wrap  = (sec_d1 == SEC_MAX_D1) && (sec_d0 == SEC_MAX_D0);

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_inc (
        .ck   (ck),
        .rst_n(rst_n),
        .en   (in_set),
        .clr  (mode_edge),
        .btn  (btn_inc),
        .step (step)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            mode      <= MODE_RUN;
            mode_prev <= 1'b0;
            presc     <= '0;
            bcnt      <= '0;
            sec_d1    <= 4'd0;
            sec_d0    <= 4'd0;
            up60      <= 1'b0;
            up24      <= 1'b0;
            blink     <= 1'b0;
        end else begin
            mode_prev <= btn_mode;
            up60      <= 1'b0;
            up24      <= 1'b0;
            // a mode edge overrides both the tick and any inc step
            if (mode_edge) begin
                mode  <= next_mode(mode);
                presc <= '0;
                bcnt  <= '0;
                blink <= (next_mode(mode) != MODE_RUN);
                if (mode == MODE_RUN) begin
                    sec_d1 <= 4'd0;
                    sec_d0 <= 4'd0;
                end
            end else if (!in_set) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (sec_d0 == 4'd9) begin
                        sec_d0 <= 4'd0;
                        sec_d1 <= sec_wrap ? 4'd0 : sec_d1 + 4'd1;
                    end else begin
                        sec_d0 <= sec_d0 + 4'd1;
                    end
                    up60 <= sec_wrap;
                    up24 <= sec_wrap && (min_d1 == MIN_MAX_D1)
                            && (min_d0 == MIN_MAX_D0);
                end
            end else begin
                bcnt <= (bcnt == BLINK_LAST) ? '0 : bcnt + BW'(1);
                if (bcnt == BLINK_LAST) begin
                    blink <= ~blink;
                end
                up24 <= step && (mode == MODE_SET_HOUR);
                up60 <= step && (mode == MODE_SET_MIN);
            end
        end
    end

endmodule
